// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32 decode stage: register file, immediate generation,
// load-use hazard detection and a one-entry skid register toward execute.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int CNTW = 16,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_pc,
  output logic [AW-1:0]   ex_rs1,
  output logic [AW-1:0]   ex_rs2,
  output logic [AW-1:0]   ex_rd,
  output logic            ex_is_load,
  output logic            ex_reg_we,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            load_use_stall,
  output logic [CNTW-1:0] stall_count
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [XLEN-1:0] regs [NREG];

  logic [6:0]      opcode;
  logic [AW-1:0]   rs1_idx;
  logic [AW-1:0]   rs2_idx;
  logic [AW-1:0]   rd_idx;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm;
  logic            dec_is_load;
  logic            dec_reg_we;
  logic            use_rs1;
  logic            use_rs2;
  logic            accept;
  logic            hold;

  assign opcode  = in_instr[6:0];
  assign rs1_idx = AW'(in_instr[19:15]);
  assign rs2_idx = AW'(in_instr[24:20]);
  assign rd_idx  = AW'(in_instr[11:7]);

  // Same-cycle writeback wins over the stored value; x0 never bypasses.
  always_comb begin
    rs1_val = regs[rs1_idx];
    rs2_val = regs[rs2_idx];
    if (rs1_idx == '0) begin
      rs1_val = '0;
    end else if (wb_we && (wb_rd == rs1_idx)) begin
      rs1_val = wb_data;
    end
    if (rs2_idx == '0) begin
      rs2_val = '0;
    end else if (wb_we && (wb_rd == rs2_idx)) begin
      rs2_val = wb_data;
    end
  end

  always_comb begin
    imm = '0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR:
        imm = XLEN'($signed(in_instr[31:20]));
      OP_STORE:
        imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      OP_BRANCH:
        imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                             in_instr[11:8], 1'b0}));
      OP_LUI, OP_AUIPC:
        imm = XLEN'({in_instr[31:12], 12'b0});
      OP_JAL:
        imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                             in_instr[30:21], 1'b0}));
      default:
        imm = '0;
    endcase
  end

  always_comb begin
    dec_is_load = (opcode == OP_LOAD);
    dec_reg_we  = (opcode != OP_STORE) && (opcode != OP_BRANCH);
    use_rs1     = (opcode != OP_LUI) && (opcode != OP_AUIPC) && (opcode != OP_JAL);
    use_rs2     = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  end

  assign load_use_stall = in_valid && ex_valid && ex_is_load && (ex_rd != '0) &&
                          ((use_rs1 && (rs1_idx == ex_rd)) ||
                           (use_rs2 && (rs2_idx == ex_rd)));

  // Gating with rst_n keeps fetch from seeing a handshake while reset is held.
  assign in_ready = rst_n && !flush && !load_use_stall && (!ex_valid || ex_ready);
  assign accept   = in_valid && in_ready;
  assign hold     = ex_valid && !ex_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_we && (wb_rd != '0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_pc       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_is_load  <= 1'b0;
      ex_reg_we   <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid    <= 1'b1;
      ex_rs1_data <= rs1_val;
      ex_rs2_data <= rs2_val;
      ex_imm      <= imm;
      ex_pc       <= in_pc;
      ex_rs1      <= rs1_idx;
      ex_rs2      <= rs2_idx;
      ex_rd       <= rd_idx;
      ex_is_load  <= dec_is_load;
      ex_reg_we   <= dec_reg_we;
    end else if (!hold) begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (load_use_stall && ex_ready && !flush && (stall_count != '1)) begin
      stall_count <= stall_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage.
module tb_decode_stage;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int CNTW = 4;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            ex_ready;
  logic            ex_valid;
  logic [XLEN-1:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
  logic [AW-1:0]   ex_rs1, ex_rs2, ex_rd;
  logic            ex_is_load, ex_reg_we;
  logic            wb_we;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            load_use_stall;
  logic [CNTW-1:0] stall_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(XLEN), .NREG(NREG), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_reg_we(ex_reg_we), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .load_use_stall(load_use_stall), .stall_count(stall_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] ins, input logic [XLEN-1:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_instr = 32'h0; in_pc = '0; flush = 1'b0;
    ex_ready = 1'b1; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    #2;
    check("rst_ex_valid", 64'(ex_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_stall_count", 64'(stall_count), 64'd0);
    tick; tick;
    rst_n = 1'b1; in_valid = 1'b0;

    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h100; tick;
    wb_rd = 5'd2; wb_data = 32'h22; tick;

    // Write x5 with bypass into addi x6,x5,1
    wb_rd = 5'd5; wb_data = 32'h1234;
    present(32'h00128313, 32'h1000);
    check("addi_in_ready", 64'(in_ready), 64'd1);
    tick; wb_we = 1'b0; in_valid = 1'b0;
    check("addi_valid", 64'(ex_valid), 64'd1);
    check("addi_rs1_data", 64'(ex_rs1_data), 64'h1234);
    check("addi_imm", 64'(ex_imm), 64'd1);
    check("addi_rd", 64'(ex_rd), 64'd6);
    check("addi_reg_we", 64'(ex_reg_we), 64'd1);
    check("addi_pc", 64'(ex_pc), 64'h1000);
    check("addi_rs1", 64'(ex_rs1), 64'd5);
    tick;
    check("drain_valid", 64'(ex_valid), 64'd0);

    // Load-use: lw x7,0(x1) then add x8,x7,x2
    present(32'h0000A383, 32'h1004);
    tick;
    check("lw_is_load", 64'(ex_is_load), 64'd1);
    check("lw_rs1_data", 64'(ex_rs1_data), 64'h100);
    present(32'h00238433, 32'h1008);
    check("lu_stall", 64'(load_use_stall), 64'd1);
    check("lu_in_ready", 64'(in_ready), 64'd0);
    tick;
    check("lu_bubble", 64'(ex_valid), 64'd0);
    check("lu_count", 64'(stall_count), 64'd1);
    check("lu_stall_clear", 64'(load_use_stall), 64'd0);
    tick;
    check("add_valid", 64'(ex_valid), 64'd1);
    check("add_pc", 64'(ex_pc), 64'h1008);
    check("add_rs2_data", 64'(ex_rs2_data), 64'h22);
    check("add_rd", 64'(ex_rd), 64'd8);

    // lui x7,0x38 (rs1 field = 7), then lui x9
    present(32'h000383B7, 32'h100C);
    tick;
    check("lui7_imm", 64'(ex_imm), 64'h38000);
    check("lui7_is_load", 64'(ex_is_load), 64'd0);
    present(32'hABCDE4B7, 32'h1010);
    check("lui9_no_stall", 64'(load_use_stall), 64'd0);
    tick;
    check("lui9_imm", 64'(ex_imm), 64'hABCDE000);
    present(32'h0000A383, 32'h1014);
    tick;
    present(32'h000383B7, 32'h1018);
    check("lw_lui_no_stall", 64'(load_use_stall), 64'd0);
    tick;
    check("lw_lui_pc", 64'(ex_pc), 64'h1018);
    // I-type with rs2 field = 7 after a load of x7 must not stall
    present(32'h0000A383, 32'h101C);
    tick;
    present(32'h00708413, 32'h1020);
    check("itype_rs2_no_stall", 64'(load_use_stall), 64'd0);
    tick;
    check("itype_imm", 64'(ex_imm), 64'd7);

    // Immediate formats
    present(32'hFE20AE23, 32'h1024); tick;
    check("sw_imm", 64'(ex_imm), 64'hFFFFFFFC);
    check("sw_reg_we", 64'(ex_reg_we), 64'd0);
    present(32'hFE208CE3, 32'h1028); tick;
    check("beq_imm", 64'(ex_imm), 64'hFFFFFFF8);
    check("beq_reg_we", 64'(ex_reg_we), 64'd0);
    present(32'h001000EF, 32'h102C); tick;
    check("jal_imm", 64'(ex_imm), 64'h800);
    check("jal_reg_we", 64'(ex_reg_we), 64'd1);
    present(32'hFFFFF08B, 32'h1030); tick;
    check("other_imm", 64'(ex_imm), 64'd0);

    // x0 ignores writes and never bypasses
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
    present(32'h00000193, 32'h1034); tick;
    wb_we = 1'b0;
    check("x0_read", 64'(ex_rs1_data), 64'd0);

    // Backpressure hold for 3 cycles
    present(32'h00128313, 32'h2000); tick;
    ex_ready = 1'b0;
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h5555;
    present(32'h00708413, 32'h2004);
    for (int i = 0; i < 3; i++) begin
      check("hold_in_ready", 64'(in_ready), 64'd0);
      tick;
      check("hold_pc", 64'(ex_pc), 64'h2000);
      check("hold_rs1_data", 64'(ex_rs1_data), 64'h1234);
    end
    wb_we = 1'b0;
    ex_ready = 1'b1; #1;
    check("release_in_ready", 64'(in_ready), 64'd1);
    tick;
    check("release_pc", 64'(ex_pc), 64'h2004);
    check("release_imm", 64'(ex_imm), 64'd7);
    in_valid = 1'b0; tick;
    check("release_no_dup", 64'(ex_valid), 64'd0);

    // Flush while valid with a pending instruction
    present(32'h00128313, 32'h3000); tick;
    flush = 1'b1;
    present(32'h00708413, 32'h3004);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    tick;
    check("flush_valid", 64'(ex_valid), 64'd0);
    flush = 1'b0; #1;
    tick;
    check("post_flush_valid", 64'(ex_valid), 64'd1);
    check("post_flush_pc", 64'(ex_pc), 64'h3004);
    in_valid = 1'b0; tick;

    // Saturation: lw x7,0(x7) stalls against itself every other cycle
    present(32'h0003A383, 32'h4000);
    for (int i = 0; i < 40; i++) tick;
    in_valid = 1'b0;
    check("sat_count", 64'(stall_count), 64'hF);
    tick;
    present(32'h00128313, 32'h5000); tick;
    in_valid = 1'b0; ex_ready = 1'b0; tick;
    check("pre_rst_hold", 64'(ex_valid), 64'd1);
    in_valid = 1'b1; ex_ready = 1'b1;
    #2; rst_n = 1'b0; #1;
    check("async_valid", 64'(ex_valid), 64'd0);
    check("async_pc", 64'(ex_pc), 64'd0);
    check("async_imm", 64'(ex_imm), 64'd0);
    check("async_count", 64'(stall_count), 64'd0);
    check("async_in_ready", 64'(in_ready), 64'd0);
    tick;
    rst_n = 1'b1;
    present(32'h00128313, 32'h6000); tick;
    check("rst_regfile", 64'(ex_rs1_data), 64'd0);
    check("rst_after_pc", 64'(ex_pc), 64'h6000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath and register width.
REQ-002 Parameter NREG, default 32, number of architectural registers; AW = clog2(NREG).
REQ-003 Parameter CNTW, default 16, width of the stall counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  fetch presents an instruction.
REQ-007 in_ready  output  1  stage accepts the instruction this cycle.
REQ-008 in_instr  input  32  RV32 instruction word.
REQ-009 in_pc  input  XLEN  PC of in_instr.
REQ-010 flush  input  1  kill the held and incoming instruction.
REQ-011 ex_ready  input  1  execute consumes ex_* this cycle.
REQ-012 ex_valid  output  1  ex_* fields are valid.
REQ-013 ex_rs1_data, ex_rs2_data, ex_imm, ex_pc  output  XLEN each  operands, immediate and PC.
REQ-014 ex_rs1, ex_rs2, ex_rd  output  AW each  register indices.
REQ-015 ex_is_load, ex_reg_we  output  1 each  load flag and writeback-enable flag.
REQ-016 wb_we, wb_rd, wb_data  input  1/AW/XLEN  register-file write port.
REQ-017 load_use_stall  output  1  combinational hazard indication.
REQ-018 stall_count  output  CNTW  saturating count of inserted bubbles.

Function
REQ-019 Register file: NREG x XLEN; reads combinational from in_instr[19:15]/[24:20] (upper bits truncated to AW); register 0 reads 0 and ignores writes.
REQ-020 A write to a register being read in the same cycle bypasses: the read returns wb_data.
REQ-021 Immediate by opcode[6:0]: I for 0000011/0010011/1100111; S for 0100011; B for 1100011; U for 0110111/0010111; J for 1101111; all other opcodes give 0; I/S/B/J sign-extended to XLEN; U = instr[31:12]<<12.
REQ-022 reg_we = 1 except for opcodes 0100011 and 1100011; is_load = (opcode == 0000011).
REQ-023 The rs1 hazard check applies to every opcode except U and J; the rs2 hazard check applies to 0110011, 0100011 and 1100011 only.
REQ-024 load_use_stall = in_valid & ex_valid & ex_is_load & (ex_rd != 0) & (the rs1 or rs2 index matches ex_rd under REQ-023).
REQ-025 in_ready = ~flush & ~load_use_stall & (~ex_valid | ex_ready).
REQ-026 Accept (in_valid & in_ready): the next edge loads all ex_* fields and sets ex_valid = 1; latency is 1 cycle.
REQ-027 Held (ex_valid & ~ex_ready & ~flush): all ex_* fields stay bit-stable; the stage does not refresh operands, and forwarding belongs to execute.
REQ-028 Drained with no accept (ex_ready, or ~ex_valid, with no accept): ex_valid <= 0 on the next edge.
REQ-029 Stall with ex_ready = 1: exactly one bubble is inserted (ex_valid <= 0); the instruction is accepted on the following cycle.
REQ-030 flush has priority over all other events: the next edge sets ex_valid <= 0 and nothing is accepted; register-file writes proceed.
REQ-031 stall_count increments on each edge where load_use_stall & ex_ready & ~flush, and saturates at all-ones.

Reset
REQ-032 While rst_n = 0, asynchronously: ex_valid = 0, every ex_* field = 0, stall_count = 0, and all registers = 0.
REQ-033 Reset asserted mid-transfer discards the held instruction; in_ready may be 1 only when rst_n = 1.

Verification
REQ-034 Write x5 = 0x1234 via wb and, in the same cycle, present addi x6,x5,1 (0x00128313) -> next cycle ex_rs1_data = 0x1234, ex_imm = 1, ex_rd = 6, ex_reg_we = 1.
REQ-035 lw x7,0(x1) accepted, then add x8,x7,x2 with ex_ready = 1 -> load_use_stall = 1 for 1 cycle, ex_valid = 0 for 1 cycle, then add issues; stall_count = 1.
REQ-036 lui x7 in EX marked ex_is_load = 0, then lui x9 -> no stall; after lw x7, lui x7 follows -> no stall (U-type).
REQ-037 Hold ex_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0 and ex_* stable; on release, the next instruction is accepted with no loss or duplication.
REQ-038 Assert flush while ex_valid = 1 and in_valid = 1 -> next cycle ex_valid = 0, and the pending instruction is accepted only after flush deasserts.
REQ-039 Force 2^CNTW + 2 stalls -> stall_count holds at all-ones; pulse rst_n low mid-hold -> outputs 0 immediately, without waiting for a clock edge.
